layer0_maxpool: RTL and testbench

Layer-0 2×2/stride-2 max-pooling stage directly downstream of the layer-0 LeakyReLU output stream. Consumes 64-bit beats (8 signed int8 channel lanes of one pixel, row-major, one frame per `s_last`). Emits one pooled 64-bit beat per 2×2 pixel window to the next convolution stage. Ready/valid on both sides, full throughput, single-register output.

---
 rtl/layer0_pkg.sv | 13 +
 rtl/int8x8_max.sv | 23 ++
 rtl/layer0_maxpool.sv | 99 +++++++++
 tb/tb_layer0_maxpool.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer0_pkg.sv
// Shared types and sizes for the layer-0 datapath: 8 signed int8 lanes per 64-bit beat.
package layer0_pkg;
  localparam int LANES  = 8;
  localparam int LANE_W = 8;
  localparam int BEAT_W = LANES * LANE_W;

  typedef logic signed [LANE_W-1:0] int8_t;
  typedef int8_t [LANES-1:0] lane_vec_t;

  function automatic int8_t max_s8(input int8_t a, input int8_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/int8x8_max.sv
// Combinational lane-wise signed maximum of two 8x int8 beats.
module int8x8_max
  import layer0_pkg::*;
(
  input  logic [BEAT_W-1:0] a,
  input  logic [BEAT_W-1:0] b,
  output logic [BEAT_W-1:0] y
);
  lane_vec_t a_v;
  lane_vec_t b_v;
  lane_vec_t y_v;

  assign a_v = a;
  assign b_v = b;
  assign y   = y_v;

  always_comb begin
    y_v = '0;
    for (int k = 0; k < LANES; k++) begin
      y_v[k] = max_s8(a_v[k], b_v[k]);
    end
  end
endmodule

// File: rtl/layer0_maxpool.sv
// 2x2 / stride-2 max pooling over a row-major int8x8 pixel stream; one output
// register stage, ready/valid on both sides, frame length checked against s_last.
module layer0_maxpool
  import layer0_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 4
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              frame_err
);
  localparam int BW    = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int CW    = BW + 1;
  localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = 1 << BW;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [BEAT_W-1:0] hold;
  logic [BEAT_W-1:0] lbuf [DEPTH];
  logic [BEAT_W-1:0] hmax_p0;
  logic [BEAT_W-1:0] vmax_p0;
  logic              xfer_p0;
  logic              at_final_p0;
  logic              err_p0;
  logic              pair_p0;
  logic              load_p0;

  // Stage p0: input transfer, horizontal and vertical reduction
  assign s_ready     = !m_valid || m_ready;
  assign xfer_p0     = s_valid && s_ready;
  assign at_final_p0 = (col == COL_LAST) && (row == ROW_LAST);
  assign err_p0      = xfer_p0 && (s_last != at_final_p0);
  assign pair_p0     = xfer_p0 && col[0];
  assign load_p0     = pair_p0 && row[0];

  int8x8_max u_hmax (
    .a (hold),
    .b (s_data),
    .y (hmax_p0)
  );

  int8x8_max u_vmax (
    .a (lbuf[col[BW:1]]),
    .b (hmax_p0),
    .y (vmax_p0)
  );

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_p0;
      if (xfer_p0) begin
        // A length mismatch resynchronises so the next beat starts a new frame
        if (err_p0 || at_final_p0) begin
          col <= '0;
          row <= '0;
        end else if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) hold <= s_data;
      end
      // Stage p1: output register, loading takes priority over draining
      if (load_p0) begin
        m_valid <= 1'b1;
        m_data  <= vmax_p0;
        m_last  <= at_final_p0;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Even rows write, odd rows read, so an entry is never written and read together
  always_ff @(posedge sclk) begin
    if (pair_p0 && !row[0]) lbuf[col[BW:1]] <= hmax_p0;
  end
endmodule

// File: tb/tb_layer0_maxpool.sv
// Randomised bench for layer0_maxpool with a window-max reference model.
module tb_layer0_maxpool;
  localparam int W = 8;
  localparam int H = 4;
  localparam int NOUT = (W / 2) * (H / 2);

  logic        sclk = 1'b0;
  logic        s_rst;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        frame_err;

  always #5 sclk = ~sclk;

  layer0_maxpool #(.IMG_W(W), .IMG_H(H)) dut (
    .sclk      (sclk),
    .s_rst     (s_rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_err (frame_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] frame [H][W];
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  bit          rand_ready = 0;
  int          stall_err = 0;
  int          err_cycles = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  // Output monitor: collects accepted beats, checks stall stability, counts error cycles
  initial begin
    forever begin
      @(negedge sclk);
      if (s_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
          stall_err++;
        if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back({m_last, m_data});
        if (frame_err === 1'b1) err_cycles++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic build_expected();
    for (int r = 0; r < H / 2; r++) begin
      for (int c = 0; c < W / 2; c++) begin
        logic [63:0] o;
        o = '0;
        for (int k = 0; k < 8; k++) begin
          int m;
          m = -1000;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              int v;
              v = int'($signed(frame[2*r+dy][2*c+dx][8*k +: 8]));
              if (v > m) m = v;
            end
          o[8*k +: 8] = 8'(m);
        end
        exp_q.push_back({(r == H/2-1) && (c == W/2-1), o});
      end
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = {8{8'(r * 8 + c)}};
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    bit acc;
    acc = 0;
    s_data = d;
    s_valid = 1'b1;
    s_last = l;
    for (int n = 0; n < 200 && !acc; n++) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      @(negedge sclk);
      acc = (s_ready === 1'b1);
      @(posedge sclk);
      #1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready stayed %b, required 1", s_ready);
    end
  endtask

  task automatic send_frame(input bit with_last);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_beat(frame[r][c], with_last && (r == H-1) && (c == W-1));
  endtask

  task automatic test_reset();
    s_rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    idle(3);
    checks += 5;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b required 0", m_last); end
    if (m_data !== 64'h0) begin errors++; $display("FAIL reset_m_data: got %h required 0", m_data); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    s_rst = 1'b0;
    idle(1);
  endtask

  task automatic test_ramp();
    logic [7:0] ramp_exp [NOUT];
    ramp_exp = '{8'd9, 8'd11, 8'd13, 8'd15, 8'd25, 8'd27, 8'd29, 8'd31};
    got_q.delete(); err_cycles = 0;
    fill_ramp();
    send_frame(1);
    idle(3);
    checks++;
    if (got_q.size() != NOUT) begin errors++; $display("FAIL ramp_count: got %0d required %0d", got_q.size(), NOUT); end
    for (int i = 0; i < NOUT && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {i == NOUT-1, {8{ramp_exp[i]}}}) begin
        errors++;
        $display("FAIL ramp_beat%0d: got %h required %h", i, got_q[i], {i == NOUT-1, {8{ramp_exp[i]}}});
      end
    end
    checks++;
    if (err_cycles != 0) begin errors++; $display("FAIL ramp_frame_err: got %0d cycles required 0", err_cycles); end
  endtask

  task automatic test_signed();
    got_q.delete(); exp_q.delete();
    fill_random();
    frame[0][0][7:0] = 8'h80; frame[0][1][7:0] = 8'hFF; frame[1][0][7:0] = 8'h00; frame[1][1][7:0] = 8'h81;
    frame[0][0][15:8] = 8'h80; frame[0][1][15:8] = 8'hFE; frame[1][0][15:8] = 8'hFF; frame[1][1][15:8] = 8'h90;
    build_expected();
    send_frame(1);
    idle(3);
    checks += 3;
    if (got_q.size() != NOUT) begin errors++; $display("FAIL signed_count: got %0d required %0d", got_q.size(), NOUT); end
    if (got_q.size() > 0 && got_q[0][7:0] !== 8'h00) begin errors++; $display("FAIL signed_mixed_lane: got %h required 00", got_q[0][7:0]); end
    if (got_q.size() > 0 && got_q[0][15:8] !== 8'hFF) begin errors++; $display("FAIL signed_negative_lane: got %h required ff", got_q[0][15:8]); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL signed_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete(); exp_q.delete(); stall_err = 0;
    rand_ready = 1;
    fill_ramp(); build_expected(); send_frame(1);
    fill_random(); build_expected(); send_frame(1);
    rand_ready = 0; m_ready = 1'b1;
    idle(4);
    checks += 2;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d violations required 0", stall_err); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_early_last();
    got_q.delete(); exp_q.delete(); err_cycles = 0;
    fill_random(); build_expected();
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    for (int i = 0; i < 20; i++) send_beat(frame[i / W][i % W], i == 19);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL early_err_pulse: got %b required 1", frame_err); end
    idle(1);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL early_err_width: got %b required 0", frame_err); end
    fill_random(); build_expected(); send_frame(1);
    idle(3);
    checks += 2;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL early_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    if (err_cycles != 1) begin errors++; $display("FAIL early_err_cycles: got %0d required 1", err_cycles); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL early_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_missing_last();
    got_q.delete(); exp_q.delete(); err_cycles = 0;
    fill_random(); build_expected(); send_frame(0);
    fill_random(); build_expected(); send_frame(1);
    idle(3);
    checks += 2;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL nolast_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    if (err_cycles != 1) begin errors++; $display("FAIL nolast_err_cycles: got %0d required 1", err_cycles); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL nolast_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    fill_random();
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) send_beat(frame[i / W][i % W], 1'b0);
    m_ready = 1'b0;
    send_beat(frame[1][3], 1'b0);
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL rst_held_before: got %b required 1", m_valid); end
    s_rst = 1'b1;
    idle(1);
    checks += 5;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_m_valid: got %b required 0", m_valid); end
    if (m_data !== 64'h0) begin errors++; $display("FAIL rst_mid_m_data: got %h required 0", m_data); end
    if (m_last !== 1'b0) begin errors++; $display("FAIL rst_mid_m_last: got %b required 0", m_last); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_err: got %b required 0", frame_err); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_s_ready: got %b required 1", s_ready); end
    s_rst = 1'b0; m_ready = 1'b1;
    got_q.delete(); exp_q.delete();
    fill_random(); build_expected(); send_frame(1);
    idle(3);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_fresh_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_fresh_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete(); err_cycles = 0;
    fill_random(); build_expected(); send_frame(1);
    fill_random(); build_expected(); send_frame(1);
    idle(3);
    checks += 4;
    if (got_q.size() != 2 * NOUT) begin errors++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), 2 * NOUT); end
    if (got_q.size() == 2 * NOUT && got_q[NOUT-1][64] !== 1'b1) begin errors++; $display("FAIL b2b_last8: got %b required 1", got_q[NOUT-1][64]); end
    if (got_q.size() == 2 * NOUT && got_q[2*NOUT-1][64] !== 1'b1) begin errors++; $display("FAIL b2b_last16: got %b required 1", got_q[2*NOUT-1][64]); end
    if (err_cycles != 0) begin errors++; $display("FAIL b2b_frame_err: got %0d cycles required 0", err_cycles); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
